drum_mult_pipe: RTL

//  Pipelined, parametrised DRUM approximate multiplier with valid/ready handshake.
//  Per operand: leading-one detect, truncate to K bits with unbiasing LSB forced to 1,

---
 rtl/drum_pkg.sv | 20 ++
 rtl/drum_mult_pipe_lod_enc.sv | 33 +++
 rtl/drum_mult_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/drum_pkg.sv
// Shared constants and width helpers for the DRUM approximate multiplier.
// Optional exact-product path is enabled by defining DRUM_EXACT_MODE_EN.
package drum_pkg;

    // Number of pipeline stages between acceptance and output.
    localparam int STAGES = 3;

    // Default truncated mantissa width.
    localparam int K_DEF = 4;

    // Width of a shift field able to hold any shift for a w-bit operand.
    function automatic int shift_w(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/drum_mult_pipe_lod_enc.sv
// Leading-one encoder for one DRUM operand: magnitude -> truncated mantissa
// with forced-1 unbiasing LSB, plus the shift that restores its weight.
module drum_lod_enc
    import drum_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int W  = 8,
    parameter int SW = shift_w(W)
) (
    input  logic [W-1:0]  mag,
    output logic [K-1:0]  mant,
    output logic [SW-1:0] shift
);

    localparam int PW = $clog2(W);

    logic [PW-1:0] pos;

    // Find the leading one, then keep K bits below it (small values pass exactly).
    always_comb begin
        pos   = '0;
        mant  = mag[K-1:0];
        shift = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) pos = PW'(i);
        end
        if (int'(pos) >= K) begin
            mant  = K'(mag >> (int'(pos) - K + 1)) | K'(1);
            shift = SW'(int'(pos) - K + 1);
        end
    end

endmodule

// File: rtl/drum_mult_pipe.sv
// Three-stage DRUM approximate multiplier with valid/ready on both sides.
// S1: sign + magnitudes, S2: leading-one truncation, S3: multiply, shift, sign.
// Define DRUM_EXACT_MODE_EN to honour in_exact with a full-width product.
module drum_mult_pipe
    import drum_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int TAG_W  = 4,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   out_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SA = shift_w(N);
    localparam int SB = shift_w(M);
    localparam int SS = max_i(SA, SB) + 1;

    logic [STAGES:1]   vld_q, vld_d, ld;
    logic [N-1:0]      mag_a_q, mag_a_d;
    logic [M-1:0]      mag_b_q, mag_b_d;
    logic              neg1_q, neg1_d, neg2_q, neg2_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d, otag_q, otag_d;
    logic [K-1:0]      mm_q, mm_d, nn_q, nn_d;
    logic [SS-1:0]     sh_q, sh_d;
    logic [N+M-1:0]    r_q, r_d, prod;
    logic [K-1:0]      mant_a, mant_b;
    logic [SA-1:0]     sh_a;
    logic [SB-1:0]     sh_b;
    logic              a_neg, b_neg;
`ifdef DRUM_EXACT_MODE_EN
    logic              ex1_q, ex1_d, ex2_q, ex2_d;
    logic [N-1:0]      fa_q, fa_d;
    logic [M-1:0]      fb_q, fb_d;
`else
    logic              unused_exact;
    assign unused_exact = in_exact;
`endif

    drum_lod_enc #(.K(K), .W(N), .SW(SA)) u_enc_a (.mag(mag_a_q), .mant(mant_a), .shift(sh_a));
    drum_lod_enc #(.K(K), .W(M), .SW(SB)) u_enc_b (.mag(mag_b_q), .mant(mant_b), .shift(sh_b));

    // Stage loads when empty or its content moves on; valid bits follow.
    always_comb begin
        ld[3]    = !vld_q[3] || out_ready;
        ld[2]    = !vld_q[2] || ld[3];
        ld[1]    = !vld_q[1] || ld[2];
        in_ready = ld[1];
        vld_d[1] = ld[1] ? in_valid : vld_q[1];
        vld_d[2] = ld[2] ? vld_q[1] : vld_q[2];
        vld_d[3] = ld[3] ? vld_q[2] : vld_q[3];
    end

    // S1: result sign and two's complement magnitudes (most negative maps to 2^(W-1)).
    always_comb begin
        a_neg   = (SIGNED != 0) && in_a[N-1];
        b_neg   = (SIGNED != 0) && in_b[M-1];
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg1_d  = neg1_q;
        tag1_d  = tag1_q;
`ifdef DRUM_EXACT_MODE_EN
        ex1_d   = ex1_q;
`endif
        if (ld[1] && in_valid) begin
            mag_a_d = a_neg ? -in_a : in_a;
            mag_b_d = b_neg ? -in_b : in_b;
            neg1_d  = a_neg ^ b_neg;
            tag1_d  = in_tag;
`ifdef DRUM_EXACT_MODE_EN
            ex1_d   = in_exact;
`endif
        end
    end

    // S2: register truncated mantissas and combined shift.
    always_comb begin
        mm_d   = mm_q;
        nn_d   = nn_q;
        sh_d   = sh_q;
        neg2_d = neg2_q;
        tag2_d = tag2_q;
`ifdef DRUM_EXACT_MODE_EN
        ex2_d  = ex2_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
`endif
        if (ld[2] && vld_q[1]) begin
            mm_d   = mant_a;
            nn_d   = mant_b;
            sh_d   = SS'(sh_a) + SS'(sh_b);
            neg2_d = neg1_q;
            tag2_d = tag1_q;
`ifdef DRUM_EXACT_MODE_EN
            ex2_d  = ex1_q;
            fa_d   = mag_a_q;
            fb_d   = mag_b_q;
`endif
        end
    end

    // S3: multiply, restore weight, reapply sign; output holds while stalled.
    always_comb begin
        prod = ((N+M)'(mm_q) * (N+M)'(nn_q)) << sh_q;
`ifdef DRUM_EXACT_MODE_EN
        if (ex2_q) prod = (N+M)'(fa_q) * (N+M)'(fb_q);
`endif
        r_d    = r_q;
        otag_d = otag_q;
        if (ld[3] && vld_q[2]) begin
            r_d    = neg2_q ? -prod : prod;
            otag_d = tag2_q;
        end
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg1_q  <= 1'b0;
            tag1_q  <= '0;
            mm_q    <= '0;
            nn_q    <= '0;
            sh_q    <= '0;
            neg2_q  <= 1'b0;
            tag2_q  <= '0;
            r_q     <= '0;
            otag_q  <= '0;
`ifdef DRUM_EXACT_MODE_EN
            ex1_q   <= 1'b0;
            ex2_q   <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
`endif
        end else begin
            vld_q   <= vld_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg1_q  <= neg1_d;
            tag1_q  <= tag1_d;
            mm_q    <= mm_d;
            nn_q    <= nn_d;
            sh_q    <= sh_d;
            neg2_q  <= neg2_d;
            tag2_q  <= tag2_d;
            r_q     <= r_d;
            otag_q  <= otag_d;
`ifdef DRUM_EXACT_MODE_EN
            ex1_q   <= ex1_d;
            ex2_q   <= ex2_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
`endif
        end
    end

    assign out_valid = vld_q[3];
    assign out_r     = r_q;
    assign out_tag   = otag_q;

endmodule
